// File: rtl/rc_pkg.sv
// Shared definitions for the result checker: FSM encoding and table geometry helpers.
package rc_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_TOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE,
    ST_TOUT = S_TOUT
  } rc_state_t;

  // One table entry holds {mask, data}.
  function automatic int entry_w(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/result_table.sv
// Expected-value table: DEPTH x {mask,data}, one synchronous write port, one asynchronous read port.
module result_table
  import rc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = addr_w(DEPTH)
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [AW-1:0]              waddr,
  input  logic [entry_w(DATA_W)-1:0] wdata,
  input  logic [AW-1:0]              raddr,
  output logic [entry_w(DATA_W)-1:0] rdata
);

  localparam int EW = entry_w(DATA_W);

  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Combinational read sees the pre-write contents when read and write hit the same entry.
  assign rdata = mem[raddr];

endmodule

// File: rtl/result_checker.sv
// Compares a stream of results against a masked expected table; counts passes/fails,
// captures the first mismatch and raises a timeout when results stop arriving.
module result_checker
  import rc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int IDX_W   = $clog2(DEPTH + 1),
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0] exp_mask,
  input  logic [IDX_W-1:0]  exp_count,
  input  logic              start,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              all_pass,
  output logic [IDX_W-1:0]  pass_count,
  output logic [IDX_W-1:0]  fail_count,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] first_fail_data,
  output logic [1:0]        fsm_state
);

  localparam int AW   = addr_w(DEPTH);
  localparam int EW   = entry_w(DATA_W);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  rc_state_t         state, state_nxt;
  logic [IDX_W-1:0]  count, idx, cnt_in;
  logic [WD_W-1:0]   watchdog;
  logic              start_run, take, tick;
  logic              table_we, mismatch;
  logic [EW-1:0]     entry;

  assign table_we = exp_we && (exp_addr < IDX_W'(DEPTH));
  assign cnt_in   = (exp_count > IDX_W'(DEPTH)) ? IDX_W'(DEPTH) : exp_count;

  result_table #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_table (
    .clk   (clk),
    .we    (table_we),
    .waddr (exp_addr[AW-1:0]),
    .wdata ({exp_mask, exp_data}),
    .raddr (idx[AW-1:0]),
    .rdata (entry)
  );

  assign mismatch = |((res_data ^ entry[DATA_W-1:0]) & entry[EW-1:DATA_W]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    take      = 1'b0;
    tick      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_TOUT: begin
        if (start) begin
          start_run = 1'b1;
          state_nxt = (cnt_in == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (res_valid) begin
          take = 1'b1;
          if (idx == count - IDX_W'(1)) state_nxt = ST_DONE;
        end else begin
          tick = 1'b1;
          if (watchdog == WD_W'(TIMEOUT - 1)) state_nxt = ST_TOUT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count           <= '0;
      idx             <= '0;
      pass_count      <= '0;
      fail_count      <= '0;
      first_fail_idx  <= '0;
      first_fail_data <= '0;
      watchdog        <= '0;
    end else if (start_run) begin
      count           <= cnt_in;
      idx             <= '0;
      pass_count      <= '0;
      fail_count      <= '0;
      first_fail_idx  <= '0;
      first_fail_data <= '0;
      watchdog        <= '0;
    end else if (take) begin
      idx      <= idx + IDX_W'(1);
      watchdog <= '0;
      if (mismatch) begin
        fail_count <= fail_count + IDX_W'(1);
        if (fail_count == '0) begin
          first_fail_idx  <= idx;
          first_fail_data <= res_data;
        end
      end else begin
        pass_count <= pass_count + IDX_W'(1);
      end
    end else if (tick) begin
      watchdog <= watchdog + WD_W'(1);
    end
  end

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE) || (state == ST_TOUT);
  assign timeout   = (state == ST_TOUT);
  assign all_pass  = (state == ST_DONE) && (fail_count == '0);
  assign fsm_state = state;

endmodule

// File: tb/tb_result_checker.sv
// Scoreboard bench for result_checker: directed runs push expected end-of-run records,
// a monitor pops and compares them each time a run completes.
module tb_result_checker;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 32;
  localparam int IDX_W   = 6;
  localparam int TIMEOUT = 64;
  localparam int RW      = 2 + 3 * IDX_W + DATA_W;

  logic              clk, reset;
  logic              exp_we, start, res_valid;
  logic [IDX_W-1:0]  exp_addr, exp_count;
  logic [DATA_W-1:0] exp_data, exp_mask, res_data;
  logic              busy, done, timeout, all_pass;
  logic [IDX_W-1:0]  pass_count, fail_count, first_fail_idx;
  logic [DATA_W-1:0] first_fail_data;
  logic [1:0]        fsm_state;

  int tests = 0;
  int fails = 0;
  logic [RW-1:0] exp_q[$];
  bit armed = 1'b0;

  logic [31:0] vals [20] = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h5, 32'h7, 32'h8, 32'hB, 32'h3,
                             32'hFFFFFFFE, 32'h0, 32'h5, 32'h1, 32'hFFFFFFF4, 32'h4D2,
                             32'hFFFFF8D7, 32'h1, 32'hFFFFFB2C, 32'h30, 32'h30};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  result_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .exp_we          (exp_we),
    .exp_addr        (exp_addr),
    .exp_data        (exp_data),
    .exp_mask        (exp_mask),
    .exp_count       (exp_count),
    .start           (start),
    .res_valid       (res_valid),
    .res_data        (res_data),
    .busy            (busy),
    .done            (done),
    .timeout         (timeout),
    .all_pass        (all_pass),
    .pass_count      (pass_count),
    .fail_count      (fail_count),
    .first_fail_idx  (first_fail_idx),
    .first_fail_data (first_fail_data),
    .fsm_state       (fsm_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic to, input logic ap, input int p, input int f,
                          input int fi, input logic [DATA_W-1:0] fd);
    exp_q.push_back({to, ap, IDX_W'(p), IDX_W'(f), IDX_W'(fi), fd});
  endtask

  // Monitor: a run is armed when start is accepted; its record is checked once done shows.
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (!reset) begin
      armed = 1'b0;
    end else begin
      if (armed && done) begin
        armed = 1'b0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: got a completed run, expected none");
        end else begin
          e = exp_q.pop_front();
          chk("run_timeout",    32'(timeout),         32'(e[RW-1]));
          chk("run_all_pass",   32'(all_pass),        32'(e[RW-2]));
          chk("run_pass_count", 32'(pass_count),      32'(e[DATA_W+2*IDX_W +: IDX_W]));
          chk("run_fail_count", 32'(fail_count),      32'(e[DATA_W+IDX_W +: IDX_W]));
          chk("run_ff_idx",     32'(first_fail_idx),  32'(e[DATA_W +: IDX_W]));
          chk("run_ff_data",    first_fail_data,      e[DATA_W-1:0]);
        end
      end
      if (start && !busy) armed = 1'b1;
    end
  end

  // Driver tasks: each starts just after a rising edge and ends 1 time unit after the next.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input int a, input logic [31:0] d, input logic [31:0] m);
    exp_we = 1'b1; exp_addr = IDX_W'(a); exp_data = d; exp_mask = m;
    step();
    exp_we = 1'b0;
  endtask

  task automatic start_run(input int cnt);
    exp_count = IDX_W'(cnt); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] d);
    res_valid = 1'b1; res_data = d;
    step();
    res_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      step();
      k++;
    end
    chk(name, 32'(done), 32'd1);
    step();
  endtask

  initial begin
    reset = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_mask = '0;
    exp_count = '0; start = 1'b0; res_valid = 1'b0; res_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",     32'(busy),           32'd0);
    chk("rst_done",     32'(done),           32'd0);
    chk("rst_timeout",  32'(timeout),        32'd0);
    chk("rst_all_pass", 32'(all_pass),       32'd0);
    chk("rst_pass",     32'(pass_count),     32'd0);
    chk("rst_fail",     32'(fail_count),     32'd0);
    chk("rst_ff_idx",   32'(first_fail_idx), 32'd0);
    chk("rst_ff_data",  first_fail_data,     32'd0);
    chk("rst_state",    32'(fsm_state),      32'd0);
    reset = 1'b1;
    step();

    // 1: full matching stream
    for (int i = 0; i < 20; i++) load_entry(i, vals[i], 32'hFFFFFFFF);
    push_exp(1'b0, 1'b1, 20, 0, 0, 32'h0);
    start_run(20);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 20; i++) feed(vals[i]);
    wait_done("t1_done_seen", 10);

    // 2: two corrupted results
    push_exp(1'b0, 1'b0, 18, 2, 9, 32'hFFFFFFFF);
    start_run(20);
    for (int i = 0; i < 20; i++)
      feed(i == 9 ? 32'hFFFFFFFF : (i == 14 ? 32'h0 : vals[i]));
    wait_done("t2_done_seen", 10);

    // 3/4: masked compare, upper half checked only
    load_entry(0, 32'h12340000, 32'hFFFF0000);
    push_exp(1'b0, 1'b1, 1, 0, 0, 32'h0);
    start_run(1);
    feed(32'h1234ABCD);
    wait_done("t3_done_seen", 10);
    push_exp(1'b0, 1'b0, 0, 1, 0, 32'h1235ABCD);
    start_run(1);
    feed(32'h1235ABCD);
    wait_done("t4_done_seen", 10);

    // 5: timeout after two results, then a clean rerun
    load_entry(0, 32'h0, 32'hFFFFFFFF);
    push_exp(1'b1, 1'b0, 2, 0, 0, 32'h0);
    start_run(3);
    feed(32'h0);
    feed(32'h1);
    idle(TIMEOUT - 1);
    chk("t5_not_yet_tout", 32'(timeout), 32'd0);
    wait_done("t5_done_seen", 5);
    push_exp(1'b0, 1'b1, 3, 0, 0, 32'h0);
    start_run(3);
    chk("t5_pass_cleared", 32'(pass_count), 32'd0);
    chk("t5_tout_cleared", 32'(timeout),    32'd0);
    for (int i = 0; i < 3; i++) feed(vals[i]);
    wait_done("t5b_done_seen", 10);

    // 6: zero-length run, then clamped over-length run
    push_exp(1'b0, 1'b1, 0, 0, 0, 32'h0);
    start_run(0);
    chk("t6_zero_done", 32'(done), 32'd1);
    chk("t6_zero_busy", 32'(busy), 32'd0);
    idle(1);
    for (int i = 20; i < DEPTH; i++) load_entry(i, 32'h100 + 32'(i), 32'hFFFFFFFF);
    load_entry(DEPTH, 32'hDEAD, 32'hFFFFFFFF);
    push_exp(1'b0, 1'b1, DEPTH, 0, 0, 32'h0);
    start_run(DEPTH + 5);
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (i == 25) begin
        exp_we = 1'b1; exp_addr = IDX_W'(25); exp_data = 32'hBAD; exp_mask = 32'hFFFFFFFF;
      end
      feed(i < 20 ? vals[i] : 32'h100 + 32'(i));
      exp_we = 1'b0;
    end
    chk("t6_busy_before_last", 32'(busy),       32'd1);
    chk("t6_pass_before_last", 32'(pass_count), 32'd31);
    feed(32'h100 + 32'(DEPTH - 1));
    wait_done("t6_done_seen", 10);

    // 7: reset mid-run
    start_run(20);
    for (int i = 0; i < 5; i++) feed(vals[i]);
    chk("t7_pass_mid", 32'(pass_count), 32'd5);
    reset = 1'b0;
    #1;
    chk("t7_rst_busy",  32'(busy),       32'd0);
    chk("t7_rst_pass",  32'(pass_count), 32'd0);
    chk("t7_rst_state", 32'(fsm_state),  32'd0);
    step();
    step();
    reset = 1'b1;
    for (int i = 5; i < 8; i++) feed(vals[i]);
    chk("t7_ignored_pass", 32'(pass_count), 32'd0);
    chk("t7_ignored_busy", 32'(busy),       32'd0);
    chk("t7_ignored_done", 32'(done),       32'd0);

    idle(3);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
